// File: rtl/mod_spi_if.sv
// CPU data-bus port bundle for mod_spi: fetch/data enables, addresses, direction, data.
// The CPU drives the master side; the peripheral answers on the slave side.
interface mod_spi_if;
    logic        ie;
    logic        de;
    logic [31:0] iaddr;
    logic [31:0] daddr;
    logic [1:0]  drw;
    logic [31:0] din;
    logic [31:0] iout;
    logic [31:0] dout;

    modport master (
        output ie, de, iaddr, daddr, drw, din,
        input  iout, dout
    );

    modport slave (
        input  ie, de, iaddr, daddr, drw, din,
        output iout, dout
    );
endinterface

// File: rtl/mod_spi.sv
// SPI master peripheral (mode 0, MSB first) behind the CPU data bus.
// A small TX FIFO feeds the shift engine; the last received byte is held for readout.
module mod_spi #(
    parameter int         FIFO_DEPTH = 4,
    parameter logic [7:0] DIV_RST    = 8'd3
) (
    input  logic     clk,
    input  logic     rst,
    mod_spi_if.slave bus,
    output logic     o_spi_sck,
    output logic     o_spi_mosi,
    input  logic     i_spi_miso,
    output logic     o_spi_cs_n,
    output logic     o_irq
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [7:0]  r_mem [FIFO_DEPTH];
    logic [AW:0] r_wptr, r_rptr;
    logic [7:0]  r_sh, r_rx_data, r_div, r_hcnt;
    logic [2:0]  r_bcnt;
    logic        r_samp, r_sck, r_mosi, r_cs_n, r_irq;
    logic        r_rx_valid, r_tx_ovf, r_rx_ovr, r_ien;

    logic        w_wr, w_rd, w_wr_ctrl, w_wr_tx, w_wr_div;
    logic        w_empty, w_full, w_push, w_pop, w_ovf;
    logic        w_rise, w_fall, w_done, w_busy;
    logic [7:0]  w_pop_data;
    logic [31:0] w_rdata;
    logic        w_unused;

    assign w_wr      = bus.de && (bus.drw == 2'b01);
    assign w_rd      = bus.de && (bus.drw == 2'b10);
    assign w_wr_ctrl = w_wr && (bus.daddr[3:2] == 2'd0);
    assign w_wr_tx   = w_wr && (bus.daddr[3:2] == 2'd1);
    assign w_wr_div  = w_wr && (bus.daddr[3:2] == 2'd3);

    assign w_empty    = (r_wptr == r_rptr);
    assign w_full     = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_pop_data = r_mem[r_rptr[AW-1:0]];
    // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
    assign w_push     = w_wr_tx && (!w_full || w_pop);
    assign w_ovf      = w_wr_tx && w_full && !w_pop;
    assign w_busy     = (r_state != ST_IDLE);

    assign w_unused = ^{bus.ie, bus.iaddr, bus.daddr[31:4], bus.daddr[1:0], bus.din[31:9]};

    // FIFO storage
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr[AW-1:0]] <= bus.din[7:0];
        end
    end

    // FIFO pointers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + PTR_ONE;
            if (w_pop)  r_rptr <= r_rptr + PTR_ONE;
        end
    end

    // Engine state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    // Engine next state and per-cycle strobes
    always_comb begin
        w_next = r_state;
        w_pop  = 1'b0;
        w_rise = 1'b0;
        w_fall = 1'b0;
        w_done = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_empty) begin
                    w_pop  = 1'b1;
                    w_next = ST_SHIFT;
                end else begin
                    w_next = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (r_hcnt == 8'd0) begin
                    if (!r_sck) begin
                        w_rise = 1'b1;
                        w_next = ST_SHIFT;
                    end else begin
                        w_fall = 1'b1;
                        w_next = (r_bcnt == 3'd0) ? ST_DONE : ST_SHIFT;
                    end
                end else begin
                    w_next = ST_SHIFT;
                end
            end
            ST_DONE: begin
                w_done = 1'b1;
                if (!w_empty) begin
                    w_pop  = 1'b1;
                    w_next = ST_SHIFT;
                end else begin
                    w_next = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Shift datapath and SPI pins
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sh   <= 8'd0;
            r_samp <= 1'b0;
            r_bcnt <= 3'd0;
            r_hcnt <= 8'd0;
            r_sck  <= 1'b0;
            r_mosi <= 1'b0;
            r_cs_n <= 1'b1;
        end else if (w_pop) begin
            r_sh   <= w_pop_data;
            r_mosi <= w_pop_data[7];
            r_bcnt <= 3'd7;
            r_hcnt <= r_div;
            r_sck  <= 1'b0;
            r_cs_n <= 1'b0;
        end else if (w_rise) begin
            r_sck  <= 1'b1;
            r_samp <= i_spi_miso;
            r_hcnt <= r_div;
        end else if (w_fall) begin
            r_sck  <= 1'b0;
            r_sh   <= {r_sh[6:0], r_samp};
            r_mosi <= r_sh[6];
            r_bcnt <= r_bcnt - 3'd1;
            r_hcnt <= r_div;
        end else if (r_state == ST_SHIFT) begin
            r_hcnt <= r_hcnt - 8'd1;
        end else if (w_done) begin
            r_cs_n <= 1'b1;
        end
    end

    // Control/status registers; a hardware set beats a same-cycle W1C clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_data  <= 8'd0;
            r_rx_valid <= 1'b0;
            r_rx_ovr   <= 1'b0;
            r_tx_ovf   <= 1'b0;
            r_ien      <= 1'b0;
            r_div      <= DIV_RST;
            r_irq      <= 1'b0;
        end else begin
            if (w_done)    r_rx_data <= r_sh;
            if (w_wr_ctrl) r_ien     <= bus.din[8];
            if (w_wr_div)  r_div     <= bus.din[7:0];
            r_rx_valid <= w_done | (r_rx_valid & ~(w_wr_ctrl & bus.din[3]));
            r_tx_ovf   <= w_ovf  | (r_tx_ovf   & ~(w_wr_ctrl & bus.din[4]));
            r_rx_ovr   <= (w_done & r_rx_valid) | (r_rx_ovr & ~(w_wr_ctrl & bus.din[5]));
            r_irq      <= r_ien & r_rx_valid;
        end
    end

    // Read mux
    always_comb begin
        w_rdata = 32'd0;
        case (bus.daddr[3:2])
            2'd0:    w_rdata = {23'd0, r_ien, 2'b00, r_rx_ovr, r_tx_ovf, r_rx_valid,
                                w_empty, w_full, w_busy};
            2'd1:    w_rdata = 32'd0;
            2'd2:    w_rdata = {24'd0, r_rx_data};
            2'd3:    w_rdata = {24'd0, r_div};
            default: w_rdata = 32'd0;
        endcase
    end

    assign bus.dout   = w_rd ? w_rdata : 32'd0;
    assign bus.iout   = 32'd0;
    assign o_spi_sck  = r_sck;
    assign o_spi_mosi = r_mosi;
    assign o_spi_cs_n = r_cs_n;
    assign o_irq      = r_irq;

endmodule
